sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out front end that assembles framed serial bits into WIDTH-bit words.
- Sits directly upstream of the 4-bit parallel load register and feeds it.
- Completed words are held in a one-entry output buffer with a valid/ready handshake.
- Lost words are reported through a sticky overflow flag.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rstn  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk by system.
- sin  input  1  serial data bit, sampled when sin_valid=1.
- sin_valid  input  1  qualifies sin for the current cycle.
- start  input  1  frame marker; marks the qualified bit as bit 0 (MSB) of a new word.
- out_ready  input  1  downstream accepts pout this cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- pout  output  WIDTH  assembled word, MSB = first received bit.
- pout_valid  output  1  pout holds an unconsumed word.
- busy  output  1  a word is partially received (state != IDLE).
- overflow  output  1  sticky: a completed word was dropped.
- par_err  output  1  one-cycle pulse on parity failure (see Optional Feature).

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; shreg=0, bit_cnt=0.
  - pout=0, pout_valid=0, overflow=0, par_err=0.
- Bit counter: bit_cnt is $clog2(WIDTH+1) bits wide. Shift rule: shreg <= {shreg[WIDTH-2:0], sin}, MSB first.
- State IDLE:
  - sin_valid=1 and start=1: shift in sin, bit_cnt=1, go to SHIFT.
  - sin_valid=1 and start=0: bit is ignored (no frame).
  - start=1 without sin_valid: ignored.
- State SHIFT (sin_valid=1):
  - If start=1: resync. Discard the partial word, take sin as bit 0, bit_cnt=1. No error flag.
  - Else: shift in sin, bit_cnt+1.
  - When this bit is the WIDTH-th: word complete, go to IDLE (or PARITY when the feature is on).
  - sin_valid=0 holds all state (stall; no timeout).
- Word completion (on the edge sampling the last bit):
  - word = {shreg[WIDTH-2:0], sin}.
  - If pout_valid=0 or out_ready=1: pout <= word, pout_valid <= 1.
  - Else: word dropped, overflow <= 1, pout unchanged.
  - Latency: pout_valid is high in the cycle after the last bit is sampled.
  - Back-to-back frames: start may arrive in the cycle immediately after completion.
- Output handshake:
  - Transfer occurs when pout_valid=1 and out_ready=1.
  - After a transfer with no simultaneous load, pout_valid <= 0 and pout keeps its value.
  - Simultaneous transfer and load: new word loaded, pout_valid stays 1.
  - pout is stable while pout_valid=1 and out_ready=0.
- overflow:
  - Set by a dropped word; cleared by clr_ovf.
  - Set and clear in the same cycle: set wins.
- busy = (state != IDLE), registered-state decode.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, the FSM enters state PARITY and waits for one more qualified bit p.
  - If ^word ^ p == 0 (even parity): word goes through the normal completion/overflow rules.
  - Else: word discarded, par_err pulses high for exactly one cycle, overflow untouched.
  - start=1 during PARITY: resync as in SHIFT, no par_err.
  - busy is high in PARITY.
  - Latency becomes one qualified bit longer.
- Undefined: no PARITY state; par_err is tied to 0.

Test Plan:
- Reset and basic frame:
  - Stimulus: rstn=0 for 2 cycles, then serial bits 1,0,1,1 with start on the first bit, out_ready=1.
  - Response: all outputs 0 during reset; pout=4'b1011 and pout_valid=1 the cycle after bit 4; pout_valid=0 one cycle later.
- Backpressure and overflow:
  - Stimulus: out_ready=0; send 4'b1011, then 4'b0110.
  - Response: pout stays 4'b1011 and overflow=1 after the second word; clr_ovf=1 then gives overflow=0.
- Simultaneous pop and load:
  - Stimulus: pout_valid=1 holding 4'b0001; out_ready=1 on the same edge that samples the last bit of 4'b1110.
  - Response: pout=4'b1110 with pout_valid staying 1.
- Stall and resync:
  - Stimulus: bits 1,0 with sin_valid gaps of 3 cycles; busy=1 throughout. Then start with bits 0,1,0,1.
  - Response: pout=4'b0101; the partial 1,0 is never output.
- Async reset mid-frame:
  - Stimulus: rstn dropped between clock edges after 2 bits.
  - Response: busy, pout and pout_valid go to 0 immediately, without waiting for a clock edge; the next frame 4'b1001 is received correctly.
- SIPO_PARITY_EN:
  - Stimulus: 4'b1011 followed by p=1 (good parity); then 4'b1011 followed by p=0 (bad parity).
  - Response: first word is output; second gives par_err as a 1-cycle pulse, no pout_valid, overflow=0.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Bus bundle for sipo_deserializer: serial input side, parallel output
// handshake and status flags. The master drives the serial stream and
// out_ready. The slave (the deserializer) drives the word and the flags.
interface sipo_deserializer_if #(
  parameter int unsigned WIDTH = 4
);

  logic             sin;
  logic             sin_valid;
  logic             start;
  logic             out_ready;
  logic             clr_ovf;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             busy;
  logic             overflow;
  logic             par_err;

  modport master (
    output sin,
    output sin_valid,
    output start,
    output out_ready,
    output clr_ovf,
    input  pout,
    input  pout_valid,
    input  busy,
    input  overflow,
    input  par_err
  );

  modport slave (
    input  sin,
    input  sin_valid,
    input  start,
    input  out_ready,
    input  clr_ovf,
    output pout,
    output pout_valid,
    output busy,
    output overflow,
    output par_err
  );

endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. It assembles framed serial bits,
// MSB first, into WIDTH-bit words.
//
// Completed words sit in a one-entry output buffer that uses a valid/ready
// handshake. A word that completes while the buffer is full and not being
// drained is dropped, and this sets the sticky overflow flag.
//
// Optional build macro SIPO_PARITY_EN: each frame carries one extra
// even-parity bit after the data bits. A word whose parity is bad is
// discarded and par_err pulses for one cycle. When the macro is not
// defined, par_err is tied low.
module sipo_deserializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  sipo_deserializer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;
`endif

  state_e             state_q,      state_d;
  logic [WIDTH-1:0]   shreg_q,      shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q,    bit_cnt_d;
  logic [WIDTH-1:0]   pout_q,       pout_d;
  logic               pout_valid_q, pout_valid_d;
  logic               overflow_q,   overflow_d;
  logic               busy_q,       busy_d;
`ifdef SIPO_PARITY_EN
  logic               par_err_q,    par_err_d;
`endif

  // Word-complete request from the framing FSM into the output buffer
  logic               load_c;
  logic [WIDTH-1:0]   load_word_c;
  logic [WIDTH-1:0]   word_c;

  // Framing FSM: collects qualified bits, resyncs on start, flags completion
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    load_c      = 1'b0;
    load_word_c = shreg_q;
`ifdef SIPO_PARITY_EN
    par_err_d   = 1'b0;
`endif
    word_c      = {shreg_q[WIDTH-2:0], bus.sin};

    if (bus.sin_valid) begin
      unique case (state_q)
        IDLE: begin
          // Bits outside a frame are ignored until a start marker arrives
          if (bus.start) begin
            shreg_d   = WIDTH'(bus.sin);
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
          end
        end

        SHIFT: begin
          if (bus.start) begin
            // Resync: abandon the partial word, this bit is the new MSB
            shreg_d   = WIDTH'(bus.sin);
            bit_cnt_d = CNT_W'(1);
          end else begin
            shreg_d   = word_c;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
              state_d     = PARITY;
`else
              state_d     = IDLE;
              bit_cnt_d   = '0;
              load_c      = 1'b1;
              load_word_c = word_c;
`endif
            end
          end
        end

`ifdef SIPO_PARITY_EN
        PARITY: begin
          if (bus.start) begin
            shreg_d   = WIDTH'(bus.sin);
            bit_cnt_d = CNT_W'(1);
            state_d   = SHIFT;
          end else begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            // Even parity over data plus parity bit must come out to zero
            if ((^shreg_q ^ bus.sin) == 1'b0) begin
              load_c      = 1'b1;
              load_word_c = shreg_q;
            end else begin
              par_err_d   = 1'b1;
            end
          end
        end
`endif

        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Output buffer: pop on handshake, load or drop completed words, sticky overflow
  always_comb begin
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    overflow_d   = overflow_q;

    if (pout_valid_q && bus.out_ready) begin
      pout_valid_d = 1'b0;
    end

    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end

    // A load in the same cycle as a pop refills the buffer; a drop beats clear
    if (load_c) begin
      if (!pout_valid_q || bus.out_ready) begin
        pout_d       = load_word_c;
        pout_valid_d = 1'b1;
      end else begin
        overflow_d   = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity error pulse register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.pout       = pout_q;
  assign bus.pout_valid = pout_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Testbench for sipo_deserializer. A frame-level reference model, built on
// a queue of received bits, predicts accepted words, overflow, busy and
// parity pulses. A negedge monitor pops expected words whenever the DUT
// presents a new one.
module tb_sipo_deserializer;

  localparam int unsigned WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif

  logic clk;
  logic rstn;

  sipo_deserializer_if #(.WIDTH(WIDTH)) bus ();

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic        bits[$];
  bit          in_frame;
  bit          m_full;
  bit          m_ovf;
  bit          m_par;
  logic [31:0] exp_q[$];

  // Frame-level model: collect qualified bits, evaluate whole frames
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bits.delete();
      in_frame = 0;
      m_full   = 0;
      m_ovf    = 0;
      m_par    = 0;
      exp_q.delete();
    end else begin
      bit          was_full;
      bit          load;
      logic [31:0] w;
      int          ones;
      was_full = m_full;
      load     = 0;
      w        = 0;
      m_par    = 0;
      if (bus.clr_ovf) m_ovf = 0;
      if (bus.sin_valid) begin
        if (bus.start) begin
          bits.delete();
          bits.push_back(bus.sin);
          in_frame = 1;
        end else if (in_frame) begin
          bits.push_back(bus.sin);
        end
        if (in_frame && bits.size() == FRAME_LEN) begin
          ones = 0;
          for (int i = 0; i < int'(WIDTH); i++) w = (w << 1) | 32'(bits[i]);
          for (int i = 0; i < int'(FRAME_LEN); i++) ones += int'(bits[i]);
          if (FRAME_LEN != WIDTH && (ones % 2) != 0) m_par = 1;
          else load = 1;
          bits.delete();
          in_frame = 0;
        end
      end
      if (was_full && bus.out_ready) m_full = 0;
      if (load) begin
        if (!was_full || bus.out_ready) begin
          exp_q.push_back(w);
          m_full = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  // Monitor: compare flags each cycle, pop expected word on each new presentation
  bit          seen;
  logic [31:0] last_word;
  always @(negedge clk) begin
    if (!rstn) begin
      seen = 0;
    end else begin
      chk("pout_valid", 32'(bus.pout_valid), 32'(m_full));
      chk("busy", 32'(bus.busy), 32'(in_frame));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("par_err", 32'(bus.par_err), 32'(m_par));
      if (bus.pout_valid && !seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: got %0h expected none (queue empty) at %0t", bus.pout, $time);
        end else begin
          chk("word", 32'(bus.pout), exp_q.pop_front());
        end
        last_word = 32'(bus.pout);
        seen = 1;
      end else if (bus.pout_valid && seen) begin
        chk("pout_hold", 32'(bus.pout), last_word);
      end
      if (bus.pout_valid && bus.out_ready) seen = 0;
    end
  end

  // One cycle of serial input, applied just after a rising edge
  task automatic drive(input logic s, input logic sv, input logic st);
    bus.sin       = s;
    bus.sin_valid = sv;
    bus.start     = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Full frame, MSB first, plus parity bit when enabled (bad flips it)
  task automatic send_word(input logic [WIDTH-1:0] w, input bit bad);
    for (int i = WIDTH - 1; i >= 0; i--) drive(w[i], 1'b1, (i == int'(WIDTH) - 1));
`ifdef SIPO_PARITY_EN
    drive((^w) ^ bad, 1'b1, 1'b0);
`else
    if (bad) idle(0);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rstn          = 1'b0;
    bus.sin       = 1'b0;
    bus.sin_valid = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_ovf   = 1'b0;

    // Reset: all outputs low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pout", 32'(bus.pout), 32'h0);
    chk("rst_pout_valid", 32'(bus.pout_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_overflow", 32'(bus.overflow), 32'h0);
    chk("rst_par_err", 32'(bus.par_err), 32'h0);
    rstn = 1'b1;
    idle(1);

    // Basic frame
    bus.out_ready = 1'b1;
    send_word(4'b1011, 0);
    idle(3);

    // Backpressure and overflow, then clear
    bus.out_ready = 1'b0;
    send_word(4'b1011, 0);
    send_word(4'b0110, 0);
    idle(2);
    bus.clr_ovf = 1'b1;
    idle(1);
    bus.clr_ovf = 1'b0;
    bus.out_ready = 1'b1;
    idle(2);

    // Simultaneous pop and load
    bus.out_ready = 1'b0;
    send_word(4'b0001, 0);
    idle(2);
    w = 4'b1110;
    drive(w[3], 1'b1, 1'b1);
    drive(w[2], 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    drive(w[1], 1'b1, 1'b0);
    drive(w[0], 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    drive(^w, 1'b1, 1'b0);
`else
    drive(w[1], 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    drive(w[0], 1'b1, 1'b0);
`endif
    idle(3);

    // Stall with gaps, then resync
    drive(1'b1, 1'b1, 1'b1);
    idle(3);
    drive(1'b0, 1'b1, 1'b0);
    idle(3);
    send_word(4'b0101, 0);
    idle(3);

    // Async reset mid-frame, between clock edges
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    bus.sin_valid = 1'b0;
    bus.start     = 1'b0;
    rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'h0);
    chk("arst_pout", 32'(bus.pout), 32'h0);
    chk("arst_pout_valid", 32'(bus.pout_valid), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    send_word(4'b1001, 0);
    idle(3);

`ifdef SIPO_PARITY_EN
    // Good parity then bad parity
    send_word(4'b1011, 0);
    idle(2);
    send_word(4'b1011, 1);
    idle(3);
`endif

    // Randomized traffic: gaps, resyncs, stray bits, backpressure, clears
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = ($urandom % 3) != 0;
      bus.clr_ovf   = ($urandom % 25) == 0;
      drive(1'($urandom), ($urandom % 4) != 0, ($urandom % 6) == 0);
    end

    // Drain
    bus.clr_ovf   = 1'b0;
    bus.out_ready = 1'b1;
    idle(6);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
